// File: rtl/smg_disp_sched.sv
// smg_disp_sched: shares the 4-digit BCD display bus between the background
// clock frame (with per-digit blink) and two held event frames, B over A.
module smg_disp_sched #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned HOLD_MS  = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] base_data,
  input  logic [3:0]  blink_mask,
  input  logic [1:0]  req,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  output logic [15:0] data,
  output logic [1:0]  src,
  output logic        busy
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int unsigned HW = $clog2(HOLD_MS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHOW_A = 2'd1;
  localparam logic [1:0] SHOW_B = 2'd2;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    state;
  logic [1:0]    post_state;
  logic [1:0]    state_nxt;
  logic          pend_a;
  logic          post_pend;
  logic          pend_nxt;
  logic          post_load;
  logic          hold_load;
  logic          latch_b;
  logic          expire;
  logic [15:0]   lat_a;
  logic [15:0]   lat_b;
  logic [15:0]   base_frame;

  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign expire = (state != IDLE) && tick && (hold_cnt == HW'(1));

  // Tick and blink phase run free in every state; requests never touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt == BW'(BLINK_MS - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    base_frame = base_data;
    for (int unsigned i = 0; i < 4; i++) begin
      if (blink_mask[i] && !phase) base_frame[4*i +: 4] = 4'hF;
    end
  end

  // Expiry is resolved first; a request in the same cycle is then applied
  // to the post-expiry state with the normal priority rules.
  always_comb begin
    post_state = state;
    post_pend  = pend_a;
    post_load  = 1'b0;
    if (expire) begin
      if (state == SHOW_B && pend_a) begin
        post_state = SHOW_A;
        post_pend  = 1'b0;
        post_load  = 1'b1;
      end else begin
        post_state = IDLE;
      end
    end

    state_nxt = post_state;
    pend_nxt  = post_pend;
    hold_load = post_load;
    latch_b   = 1'b0;
    case (post_state)
      SHOW_B: begin
        if (req[1]) begin
          latch_b   = 1'b1;
          hold_load = 1'b1;
        end
        if (req[0]) pend_nxt = 1'b1;
      end
      default: begin
        if (req[1]) begin
          state_nxt = SHOW_B;
          latch_b   = 1'b1;
          hold_load = 1'b1;
          if (req[0]) pend_nxt = 1'b1;
        end else if (req[0]) begin
          state_nxt = SHOW_A;
          hold_load = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_a   <= 1'b0;
      hold_cnt <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
    end else begin
      state  <= state_nxt;
      pend_a <= pend_nxt;
      if (hold_load) begin
        hold_cnt <= HW'(HOLD_MS);
      end else if (tick && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (req[0]) lat_a <= data_a;
      if (latch_b) lat_b <= data_b;
    end
  end

  // Outputs are registered from the current state, one edge behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '1;
      src  <= 2'd0;
      busy <= 1'b0;
    end else begin
      case (state)
        SHOW_A: begin
          data <= lat_a;
          src  <= 2'd1;
          busy <= 1'b1;
        end
        SHOW_B: begin
          data <= lat_b;
          src  <= 2'd2;
          busy <= 1'b1;
        end
        default: begin
          data <= base_frame;
          src  <= 2'd0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smg_disp_sched.sv
// Scenario bench for smg_disp_sched with TICK_DIV=4, HOLD_MS=3, BLINK_MS=2:
// expected display segments are queued as stimulus is driven, checked as they appear.
module tb_smg_disp_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] base_data;
  logic [3:0]  blink_mask;
  logic [1:0]  req;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] data;
  logic [1:0]  src;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
    logic        b;
    int          dmin;
    int          dmax;
  } seg_t;
  seg_t exp_q[$];

  smg_disp_sched #(.TICK_DIV(4), .HOLD_MS(3), .BLINK_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .base_data(base_data), .blink_mask(blink_mask),
    .req(req), .data_a(data_a), .data_b(data_b),
    .data(data), .src(src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ticks are sampled on edges that are multiples of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic pulse(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req = r; data_a = a; data_b = b;
    @(negedge clk);
    req = 2'b00;
  endtask

  task automatic wait_change(input int budget, output bit to);
    logic [18:0] v0;
    v0 = {data, src, busy};
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ({data, src, busy} !== v0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; base_data = 16'h1234; blink_mask = 4'b0000;
    data_a = '0; data_b = '0;
    #23;
    checks++;
    if ({data, src, busy} !== {16'hFFFF, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: data=%h src=%0d busy=%0b, expected data=ffff src=0 busy=0", data, src, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({data, src, busy} !== {16'h1234, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL first_frame: data=%h src=%0d busy=%0b, expected data=1234 src=0 busy=0", data, src, busy);
    end
  endtask

  task automatic test_single_a();
    seg_t e;
    bit to;
    int ts, ta;
    exp_q.push_back(seg_t'{16'h0007, 2'd1, 1'b1, 8, 12});
    exp_q.push_back(seg_t'{16'h1234, 2'd0, 1'b0, 0, 0});
    pulse(2'b01, 16'h0007, 16'h0000);
    ts = cyc;
    e = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b} || cyc != ts + 1) begin
      errors++;
      $display("FAIL single_a_show: data=%h src=%0d busy=%0b lat=%0d to=%0b, expected data=%h src=%0d busy=%0b lat=1",
               data, src, busy, cyc - ts, to, e.d, e.s, e.b);
    end
    ta = cyc;
    wait_change(20, to);
    checks++;
    if (to || cyc - ta < e.dmin || cyc - ta > e.dmax) begin
      errors++;
      $display("FAIL single_a_hold: held %0d cycles to=%0b, expected %0d..%0d", cyc - ta, to, e.dmin, e.dmax);
    end
    e = exp_q.pop_front();
    checks++;
    if ({data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL single_a_return: data=%h src=%0d busy=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, e.d, e.s, e.b);
    end
  endtask

  task automatic test_preempt();
    seg_t e, prev;
    bit to;
    int tp;
    exp_q.push_back(seg_t'{16'h0777, 2'd1, 1'b1, 0, 0});
    pulse(2'b01, 16'h0777, 16'h0000);
    e = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL preempt_a: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, e.d, e.s, e.b);
    end
    repeat (2) @(negedge clk);
    exp_q.push_back(seg_t'{16'h9999, 2'd2, 1'b1, 8, 12});
    pulse(2'b10, 16'h0777, 16'h9999);
    prev = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {prev.d, prev.s, prev.b}) begin
      errors++;
      $display("FAIL preempt_b: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, prev.d, prev.s, prev.b);
    end
    tp = cyc;
    repeat (3) @(negedge clk);
    exp_q.push_back(seg_t'{16'h0055, 2'd1, 1'b1, 8, 12});
    exp_q.push_back(seg_t'{16'h1234, 2'd0, 1'b0, 0, 0});
    pulse(2'b01, 16'h0055, 16'h9999);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(24, to);
      checks++;
      if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
        errors++;
        $display("FAIL preempt_seq: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
                 data, src, busy, to, e.d, e.s, e.b);
      end
      checks++;
      if (cyc - tp < prev.dmin || cyc - tp > prev.dmax) begin
        errors++;
        $display("FAIL preempt_hold: frame %h held %0d cycles, expected %0d..%0d", prev.d, cyc - tp, prev.dmin, prev.dmax);
      end
      prev = e;
      tp = cyc;
    end
  endtask

  task automatic test_simultaneous();
    seg_t e, prev;
    bit to;
    int tp;
    bit first;
    exp_q.push_back(seg_t'{16'h5555, 2'd2, 1'b1, 8, 12});
    exp_q.push_back(seg_t'{16'h0AAA, 2'd1, 1'b1, 8, 12});
    exp_q.push_back(seg_t'{16'h1234, 2'd0, 1'b0, 0, 0});
    pulse(2'b11, 16'h0AAA, 16'h5555);
    first = 1'b1;
    tp = cyc;
    prev = seg_t'{16'h0000, 2'd0, 1'b0, 0, 0};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(24, to);
      checks++;
      if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
        errors++;
        $display("FAIL simul_seq: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
                 data, src, busy, to, e.d, e.s, e.b);
      end
      if (!first) begin
        checks++;
        if (cyc - tp < prev.dmin || cyc - tp > prev.dmax) begin
          errors++;
          $display("FAIL simul_hold: frame %h held %0d cycles, expected %0d..%0d", prev.d, cyc - tp, prev.dmin, prev.dmax);
        end
      end
      first = 1'b0;
      prev = e;
      tp = cyc;
    end
    wait_change(30, to);
    checks++;
    if (!to) begin
      errors++;
      $display("FAIL simul_pend_cleared: data=%h src=%0d busy=%0b, expected base 1234 src=0 to stay", data, src, busy);
    end
  endtask

  task automatic test_expiry_collision();
    seg_t e;
    bit to;
    int ent, xp, tb;
    pulse(2'b10, 16'h0000, 16'h4444);
    ent = cyc;
    xp = 4 * (ent / 4 + 3);
    exp_q.push_back(seg_t'{16'h4444, 2'd2, 1'b1, xp - ent, xp - ent});
    exp_q.push_back(seg_t'{16'h0ABC, 2'd1, 1'b1, 8, 12});
    exp_q.push_back(seg_t'{16'h1234, 2'd0, 1'b0, 0, 0});
    e = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL collide_b: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, e.d, e.s, e.b);
    end
    tb = cyc;
    while (cyc < xp - 1) @(negedge clk);
    req = 2'b01; data_a = 16'h0ABC;
    @(negedge clk);
    req = 2'b00;
    wait_change(8, to);
    checks++;
    if (cyc - tb < e.dmin || cyc - tb > e.dmax) begin
      errors++;
      $display("FAIL collide_b_hold: held %0d cycles, expected %0d", cyc - tb, e.dmin);
    end
    e = exp_q.pop_front();
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL collide_a: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, e.d, e.s, e.b);
    end
    tb = cyc;
    wait_change(20, to);
    checks++;
    if (to || cyc - tb < e.dmin || cyc - tb > e.dmax) begin
      errors++;
      $display("FAIL collide_a_hold: held %0d cycles to=%0b, expected %0d..%0d", cyc - tb, to, e.dmin, e.dmax);
    end
    e = exp_q.pop_front();
    checks++;
    if ({data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL collide_return: data=%h src=%0d busy=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, e.d, e.s, e.b);
    end
  endtask

  task automatic test_blink();
    seg_t e;
    bit to, ok;
    int tp;
    logic [15:0] v_first, v_other;
    @(negedge clk); blink_mask = 4'b0011;
    @(posedge clk); #1;
    // Frame after edge m carries the phase set at edge m-1; phase toggles every 8 edges.
    v_first = (((cyc - 1) / 8) % 2 == 0) ? 16'h1234 : 16'h12FF;
    v_other = (v_first == 16'h1234) ? 16'h12FF : 16'h1234;
    checks++;
    if ({data, src, busy} !== {v_first, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL blink_initial: data=%h src=%0d busy=%0b, expected data=%h src=0 busy=0", data, src, busy, v_first);
    end
    exp_q.push_back(seg_t'{v_other, 2'd0, 1'b0, 8, 8});
    exp_q.push_back(seg_t'{v_first, 2'd0, 1'b0, 8, 8});
    exp_q.push_back(seg_t'{v_other, 2'd0, 1'b0, 8, 8});
    tp = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(10, to);
      checks++;
      if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
        errors++;
        $display("FAIL blink_toggle: data=%h to=%0b, expected data=%h", data, to, e.d);
      end
      if (tp >= 0) begin
        checks++;
        if (cyc - tp != e.dmin) begin
          errors++;
          $display("FAIL blink_period: half period %0d cycles, expected %0d", cyc - tp, e.dmin);
        end
      end
      tp = cyc;
    end
    exp_q.push_back(seg_t'{16'h00AB, 2'd1, 1'b1, 0, 0});
    pulse(2'b01, 16'h00AB, 16'h0000);
    e = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL blink_show_a: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, e.d, e.s, e.b);
    end
    ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (data !== e.d) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_mask_in_show_a: data=%h, expected %h held steady", data, e.d);
    end
    @(negedge clk); blink_mask = 4'b0000;
    wait_change(8, to);
    checks++;
    if (to || {data, src, busy} !== {16'h1234, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL blink_return: data=%h src=%0d busy=%0b to=%0b, expected data=1234 src=0 busy=0",
               data, src, busy, to);
    end
  endtask

  task automatic test_async_reset();
    seg_t e;
    bit to;
    exp_q.push_back(seg_t'{16'h4321, 2'd2, 1'b1, 0, 0});
    pulse(2'b10, 16'h0000, 16'h4321);
    e = exp_q.pop_front();
    wait_change(4, to);
    checks++;
    if (to || {data, src, busy} !== {e.d, e.s, e.b}) begin
      errors++;
      $display("FAIL areset_b: data=%h src=%0d busy=%0b to=%0b, expected data=%h src=%0d busy=%0b",
               data, src, busy, to, e.d, e.s, e.b);
    end
    pulse(2'b01, 16'h0666, 16'h4321);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data, src, busy} !== {16'hFFFF, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL areset_immediate: data=%h src=%0d busy=%0b, expected data=ffff src=0 busy=0", data, src, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({data, src, busy} !== {16'h1234, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL areset_idle: data=%h src=%0d busy=%0b, expected data=1234 src=0 busy=0", data, src, busy);
    end
    wait_change(30, to);
    checks++;
    if (!to) begin
      errors++;
      $display("FAIL areset_pend_lost: data=%h src=%0d busy=%0b, expected base 1234 src=0 to stay", data, src, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_preempt();
    test_simultaneous();
    test_expiry_collision();
    test_blink();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smg_disp_sched.md
# smg_disp_sched

Display scheduler for the 4-digit seven-segment path. It shares the display data bus between one background source (clock time) and two event sources (A and B). B has the higher priority. Each event source raises a request pulse and its frame is shown for a fixed hold time. While the background source is shown, individual digits can blink. The registered `data` output feeds the display driver's 16-bit BCD input, one nibble per digit with digit 0 in [3:0]. The driver renders any nibble above 9 (here 4'hF) as a blank digit.

## Interface
- `TICK_DIV`, default 50000: clk cycles per 1 ms tick, for a 50 MHz clk.
- `HOLD_MS`, default 2000: event display hold time in ticks. Must be ≥ 1.
- `BLINK_MS`, default 250: blink half-period in ticks. Must be ≥ 1.

- `clk`, in, 1: system clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous and active-low.
- `base_data`, in, 16: background BCD frame. Sampled live every cycle while in IDLE.
- `blink_mask`, in, 4: bit i set means digit i of `base_data` blinks. Applies in IDLE only.
- `req`, in, 2: single-cycle request pulses. req[0] requests source A, req[1] requests source B.
- `data_a`, in, 16: frame for A. Latched in the cycle req[0] is sampled high.
- `data_b`, in, 16: frame for B. Latched in the cycle req[1] is sampled high.
- `data`, out, 16: frame sent to the display driver, registered.
- `src`, out, 2: source currently shown. 0 = base, 1 = A, 2 = B. Registered.
- `busy`, out, 1: high in SHOW_A or SHOW_B.

## Operation
- **Tick generator:** a free-running counter runs 0..TICK_DIV-1. `tick` is a one-cycle pulse when the counter equals TICK_DIV-1. Requests never reset it.
- **Blink:** the blink counter counts ticks 0..BLINK_MS-1. On wrap, `phase` toggles. `phase` = 1 means on.
- **Background frame in IDLE:** digit i = 4'hF when blink_mask[i]=1 and phase=0. Otherwise digit i = base_data[4i+3:4i].
- **Hold counter:** loaded with HOLD_MS on every entry or retrigger. Decrements on each tick. The state expires when tick is high and the counter equals 1.
- **`pend_a`:** one flag plus a 16-bit latch, `lat_a`. Any req[0] stores data_a into `lat_a`.

State machine (IDLE, SHOW_A, SHOW_B):
- **IDLE**
  - req[1] → SHOW_B and latch data_b. If req[0] is also high, set pend_a.
  - Else req[0] → SHOW_A.
- **SHOW_A**
  - req[1] → SHOW_B, latch data_b, reload the hold counter. If req[0] is also high, set pend_a.
  - Else req[0] → retrigger: reload the hold counter and show the new data_a.
  - Expiry → IDLE.
- **SHOW_B**
  - req[1] → retrigger: reload the hold counter and relatch data_b.
  - req[0] → set pend_a. Stay in SHOW_B.
  - Expiry with pend_a=1 → SHOW_A, clear pend_a, load the hold counter.
  - Expiry with pend_a=0 → IDLE.
- **Mid-hold A request:** if SHOW_A is preempted by B, the remaining A hold time is discarded. A returns only if pend_a was set.
- **Simultaneous expiry and request:** the request wins. It is treated as arriving in the post-expiry state with the same priority rules. Example: req[0] in the SHOW_B expiry cycle → SHOW_A with the new data_a.
- **Output in SHOW_A / SHOW_B:** `data` = `lat_a` / `lat_b`. Blink is not applied.

## Timing
- **Reset values:** data=16'hFFFF (all blank), src=0, busy=0, state=IDLE, pend_a=0, phase=1, and all counters 0.
- **First cycle after reset release:** `data` follows base_data with a 1-cycle register latency.
- **Latency:** `data`, `src` and `busy` reflect a state change on the clk edge after the edge that samples req or expiry.
- **Hold duration:** an event frame is displayed for between HOLD_MS-1 and HOLD_MS full tick periods, depending on the tick phase at entry.
- **Blink phase:** runs continuously in every state, so blink phase is not realigned on return to IDLE.
- **Reset asserted mid-hold:** all outputs reach their reset values asynchronously, without waiting for clk. Pending and latched frames are lost.

## Test plan
All scenarios use TICK_DIV=4, HOLD_MS=3, BLINK_MS=2.
- **Reset:** hold rst_n=0 → data=16'hFFFF, src=0, busy=0. Release with base_data=16'h1234 and mask=0 → data=16'h1234 one cycle later.
- **Single A event:** in IDLE, pulse req[0] with data_a=16'h0007 → next cycle data=16'h0007, src=1, busy=1. Returns to data=16'h1234, src=0 after 8–12 clk cycles.
- **Preempt and pending:** during SHOW_A, pulse req[1] with data_b=16'h9999, then during SHOW_B pulse req[0] with data_a=16'h0055 → B is shown for one full hold. Then 16'h0055 with src=1 for one hold. Then base.
- **Simultaneous requests in IDLE:** pulse req=2'b11 → B is shown first, then A, then base. pend_a is cleared at A entry.
- **Blink:** IDLE with mask=4'b0011 and base_data=16'h1234 → data alternates 16'h1234 / 16'h12FF every 8 clk cycles. Mask bits are ignored while in SHOW_A.
- **Asynchronous reset mid-hold:** assert rst_n low in SHOW_B between clk edges → data=16'hFFFF and busy=0 immediately. After release, the block is in IDLE with pend_a=0.
